// File: rtl/fios_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : fios_pkg
//  Brief   : Shared limb width, collector state encoding and index-width
//            helper for the FIOS result collector.
//  Revision: 1.0  initial release
// ============================================================================
package fios_pkg;

    localparam int LIMB_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUT     = 2'd2
    } coll_state_t;

    // Width of a limb index for s limbs; never narrower than one bit.
    function automatic int limb_idx_w(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fios_result_collector_limb_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : limb_sub
//  Brief   : Combinational 17-bit subtractor with borrow-in / borrow-out,
//            one step of the limb-serial T - p subtraction.
//  Revision: 1.0  initial release
// ============================================================================
module limb_sub
    import fios_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              bin,
    output logic [LIMB_W-1:0] diff,
    output logic              bout
);

    // One extra bit on the left catches the borrow out of the limb.
    assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{LIMB_W{1'b0}}, bin};

endmodule
`default_nettype wire

// File: rtl/fios_result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : fios_result_collector
//  Brief   : Collects FIOS result limbs LSB first, subtracts the modulus
//            limb-serially on the fly and emits T mod p (T < 2p) as one
//            parallel word over a valid/ready handshake.
//  Revision: 1.0  initial release
// ============================================================================
module fios_result_collector
    import fios_pkg::*;
#(
    parameter  int S = 16,
    localparam int W = LIMB_W * S
)(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [W-1:0]      p_i,
    input  logic              res_valid_i,
    input  logic [LIMB_W-1:0] res_limb_i,
    input  logic              res_last_i,
    input  logic              res_msb_i,
    output logic              res_ready_o,
    output logic [W-1:0]      result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              err_o
);

    localparam int            KW     = limb_idx_w(S);
    localparam logic [KW-1:0] K_LAST = KW'(S - 1);
    localparam int            LO_W   = W - LIMB_W;

    coll_state_t          state;
    coll_state_t          state_nxt;
    logic [KW-1:0]        k;
    logic                 borrow;

    // Only the lower S-1 limbs are stored; the top limb is taken straight
    // from the input on the cycle the word is assembled.
    logic [LO_W-1:0]      t_lo;
    logic [LO_W-1:0]      d_lo;

    logic [LIMB_W-1:0]    p_limbs [S];
    logic [LIMB_W-1:0]    diff;
    logic                 bin;
    logic                 bout;
    int                   limb_base;

    logic                 accept;
    logic                 at_last;
    logic                 early_last;
    logic                 finish_op;
    logic                 handshake;
    logic                 select_d;

    for (genvar i = 0; i < S; i++) begin : g_plimb
        assign p_limbs[i] = p_i[i*LIMB_W +: LIMB_W];
    end

    assign accept     = res_valid_i & res_ready_o;
    assign at_last    = (k == K_LAST);
    assign early_last = accept & res_last_i & ~at_last;
    // Reaching the final index completes the word even if last is missing.
    assign finish_op  = accept & at_last;
    assign handshake  = result_valid_o & result_ready_i;
    assign bin        = (k == '0) ? 1'b0 : borrow;
    // D is the reduced value unless T < p, i.e. no overflow bit and a final borrow.
    assign select_d   = res_msb_i | ~bout;
    assign limb_base  = int'(k) * LIMB_W;

    limb_sub u_limb_sub (
        .a    (res_limb_i),
        .b    (p_limbs[k]),
        .bin  (bin),
        .diff (diff),
        .bout (bout)
    );

    // State register; limb acceptance is offered whenever the next state is not OUT.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            res_ready_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            res_ready_o <= (state_nxt != ST_OUT);
        end
    end

    // Next-state logic for the collect / output sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (finish_op) begin
                    state_nxt = ST_OUT;
                end else if (early_last) begin
                    state_nxt = ST_IDLE;
                end else if (accept) begin
                    state_nxt = ST_COLLECT;
                end
            end
            ST_OUT: begin
                if (handshake) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Limb capture, running borrow, result load and sticky protocol error.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            k              <= '0;
            borrow         <= 1'b0;
            t_lo           <= '0;
            d_lo           <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            if (res_valid_i && !res_ready_o) begin
                err_o <= 1'b1;
            end
            if (handshake) begin
                result_valid_o <= 1'b0;
            end
            if (accept) begin
                if (early_last) begin
                    err_o  <= 1'b1;
                    k      <= '0;
                    borrow <= 1'b0;
                end else if (at_last) begin
                    if (!res_last_i) begin
                        err_o <= 1'b1;
                    end
                    k              <= '0;
                    borrow         <= 1'b0;
                    result_o       <= select_d ? {diff, d_lo} : {res_limb_i, t_lo};
                    result_valid_o <= 1'b1;
                end else begin
                    t_lo[limb_base +: LIMB_W] <= res_limb_i;
                    d_lo[limb_base +: LIMB_W] <= diff;
                    borrow                    <= bout;
                    k                         <= k + KW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
